// File: rtl/arb_mux_2x1.sv
// Two-input round-robin packet arbiter feeding a registered 2:1 mux.
// A granted packet keeps the grant until its last beat; fairness rotates per packet.
module arb_mux_2x1 #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  input  logic          a_last,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  input  logic          b_last,
  output logic          b_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_sel,
  input  logic          out_ready
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] LOCK_A = 2'b01;
  localparam logic [1:0] LOCK_B = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       prio;
  logic       prio_nxt;
  logic       space;
  logic       grant_a;
  logic       grant_b;
  logic       a_xfer;
  logic       b_xfer;

  // Output register can take a beat when empty or draining this cycle.
  assign space = !out_valid || out_ready;

  // Grant: arbitrate in IDLE, otherwise only the locked owner may proceed.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: begin
        if (a_valid && (!b_valid || !prio)) begin
          grant_a = 1'b1;
        end else if (b_valid) begin
          grant_b = 1'b1;
        end
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: begin
        grant_a = 1'b0;
        grant_b = 1'b0;
      end
    endcase
  end

  assign a_ready = rst_n && grant_a && space;
  assign b_ready = rst_n && grant_b && space;
  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;

  // Next state and priority pointer; prio only moves when a packet completes.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    if (a_xfer) begin
      if (a_last) begin
        state_nxt = IDLE;
        prio_nxt  = 1'b1;
      end else begin
        state_nxt = LOCK_A;
      end
    end else if (b_xfer) begin
      if (b_last) begin
        state_nxt = IDLE;
        prio_nxt  = 1'b0;
      end else begin
        state_nxt = LOCK_B;
      end
    end else if (state != IDLE && state != LOCK_A && state != LOCK_B) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Output stage: reload on transfer, drain when consumed, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= 1'b0;
    end else if (a_xfer) begin
      out_valid <= 1'b1;
      out_data  <= a_data;
      out_last  <= a_last;
      out_sel   <= 1'b0;
    end else if (b_xfer) begin
      out_valid <= 1'b1;
      out_data  <= b_data;
      out_last  <= b_last;
      out_sel   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_2x1.sv
// Bench for arb_mux_2x1: directed scenarios plus a randomized run against a packet-level model.
module tb_arb_mux_2x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_last, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_last, b_ready;
  logic [7:0] b_data;
  logic       out_valid, out_last, out_sel, out_ready;
  logic [7:0] out_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  arb_mux_2x1 #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  task automatic drive(input logic av, input logic [7:0] ad, input logic al,
                       input logic bv, input logic [7:0] bd, input logic bl,
                       input logic ordy);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'h5A, 1'b1, 1'b1, 8'h6B, 1'b1, 1'b1);
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready_low: got %b want 00", {a_ready, b_ready});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({out_valid, out_sel, out_last, out_data} !== 11'h000) begin
        fails++; $display("FAIL reset_out_clear[%0d]: got %h want 000", i, {out_valid, out_sel, out_last, out_data});
      end
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      fails++; $display("FAIL reset_first_grant: got %b want 10", {a_ready, b_ready});
    end
    step();
    tests++;
    if ({out_valid, out_sel, out_last, out_data} !== {3'b101, 8'h5A}) begin
      fails++; $display("FAIL reset_first_beat: got %h want %h", {out_valid, out_sel, out_last, out_data}, {3'b101, 8'h5A});
    end
  endtask

  task automatic test_single_stream();
    logic [7:0] dat [3];
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, dat[i], i == 2, 1'b0, 8'h00, 1'b0, 1'b1);
      #1;
      tests++;
      if ({a_ready, b_ready} !== 2'b10) begin
        fails++; $display("FAIL single_ready[%0d]: got %b want 10", i, {a_ready, b_ready});
      end
      step();
      tests++;
      if ({out_valid, out_sel, out_last, out_data} !== {1'b1, 1'b0, i == 2, dat[i]}) begin
        fails++; $display("FAIL single_out[%0d]: got %h want %h", i, {out_valid, out_sel, out_last, out_data}, {1'b1, 1'b0, i == 2, dat[i]});
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL single_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_contention();
    logic       av [6], al [6], bv [6], bl [6];
    logic [7:0] ad [6], bd [6];
    logic [1:0] rdy [6];
    logic [10:0] ov [6];
    av = '{1, 1, 0, 0, 1, 0};           ad = '{8'hA0, 8'hA1, 0, 0, 8'hC1, 0};   al = '{0, 1, 0, 0, 1, 0};
    bv = '{1, 1, 1, 1, 1, 1};           bd = '{8'hB0, 8'hB0, 8'hB0, 8'hB1, 8'hC2, 8'hC2};
    bl = '{0, 0, 0, 1, 1, 1};
    rdy = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    ov = '{{3'b100, 8'hA0}, {3'b101, 8'hA1}, {3'b110, 8'hB0}, {3'b111, 8'hB1}, {3'b101, 8'hC1}, {3'b111, 8'hC2}};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(av[i], ad[i], al[i], bv[i], bd[i], bl[i], 1'b1);
      #1;
      tests++;
      if ({a_ready, b_ready} !== rdy[i]) begin
        fails++; $display("FAIL contention_ready[%0d]: got %b want %b", i, {a_ready, b_ready}, rdy[i]);
      end
      step();
      tests++;
      if ({out_valid, out_sel, out_last, out_data} !== ov[i]) begin
        fails++; $display("FAIL contention_out[%0d]: got %h want %h", i, {out_valid, out_sel, out_last, out_data}, ov[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    drive(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      tests++;
      if ({a_ready, b_ready} !== 2'b00) begin
        fails++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {a_ready, b_ready});
      end
      step();
      tests++;
      if ({out_valid, out_sel, out_last, out_data} !== {3'b100, 8'h40}) begin
        fails++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {out_valid, out_sel, out_last, out_data}, {3'b100, 8'h40});
      end
    end
    drive(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      fails++; $display("FAIL bp_release_ready: got %b want 10", {a_ready, b_ready});
    end
    step();
    tests++;
    if ({out_valid, out_sel, out_last, out_data} !== {3'b100, 8'h41}) begin
      fails++; $display("FAIL bp_next_beat: got %h want %h", {out_valid, out_sel, out_last, out_data}, {3'b100, 8'h41});
    end
    drive(1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    tests++;
    if ({out_valid, out_sel, out_last, out_data} !== {3'b101, 8'h42}) begin
      fails++; $display("FAIL bp_last_beat: got %h want %h", {out_valid, out_sel, out_last, out_data}, {3'b101, 8'h42});
    end
  endtask

  task automatic test_stalled_lock();
    apply_reset();
    drive(1'b1, 8'h01, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
      #1;
      tests++;
      if ({a_ready, b_ready} !== 2'b10) begin
        fails++; $display("FAIL stall_ready[%0d]: got %b want 10", i, {a_ready, b_ready});
      end
      step();
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL stall_out_empty: got %b want 0", out_valid);
    end
    drive(1'b1, 8'h02, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    step();
    tests++;
    if ({out_valid, out_sel, out_last, out_data} !== {3'b101, 8'h02}) begin
      fails++; $display("FAIL stall_resume: got %h want %h", {out_valid, out_sel, out_last, out_data}, {3'b101, 8'h02});
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b01) begin
      fails++; $display("FAIL stall_b_grant: got %b want 01", {a_ready, b_ready});
    end
    step();
    tests++;
    if ({out_valid, out_sel, out_last, out_data} !== {3'b111, 8'h77}) begin
      fails++; $display("FAIL stall_b_beat: got %h want %h", {out_valid, out_sel, out_last, out_data}, {3'b111, 8'h77});
    end
  endtask

  task automatic test_mid_packet_reset();
    apply_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1);
    step();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1);
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b00) begin
      fails++; $display("FAIL midrst_ready: got %b want 00", {a_ready, b_ready});
    end
    step();
    tests++;
    if ({out_valid, out_sel, out_last, out_data} !== 11'h000) begin
      fails++; $display("FAIL midrst_clear: got %h want 000", {out_valid, out_sel, out_last, out_data});
    end
    rst_n = 1'b1;
    drive(1'b1, 8'hA5, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b1);
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      fails++; $display("FAIL midrst_a_first: got %b want 10", {a_ready, b_ready});
    end
    step();
    tests++;
    if ({out_valid, out_sel, out_last, out_data} !== {3'b101, 8'hA5}) begin
      fails++; $display("FAIL midrst_a_beat: got %h want %h", {out_valid, out_sel, out_last, out_data}, {3'b101, 8'hA5});
    end
  endtask

  // Packet-level model: owner of an open packet, whose turn it is, and the held beat.
  task automatic test_random();
    int         owner;
    logic       turn_b;
    logic       hv, hs, hl;
    logic [7:0] hd;
    int         rem_a, rem_b, beats;
    logic       sp, ra, rb, xa, xb;
    apply_reset();
    owner = 0; turn_b = 1'b0; hv = 1'b0; hs = 1'b0; hl = 1'b0; hd = 8'h00;
    rem_a = 0; rem_b = 0; beats = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!a_valid && $urandom_range(0, 99) < 60) begin
        if (rem_a == 0) rem_a = $urandom_range(1, 4);
        a_valid = 1'b1; a_data = 8'($urandom); a_last = (rem_a == 1);
      end
      if (!b_valid && $urandom_range(0, 99) < 60) begin
        if (rem_b == 0) rem_b = $urandom_range(1, 4);
        b_valid = 1'b1; b_data = 8'($urandom); b_last = (rem_b == 1);
      end
      out_ready = ($urandom_range(0, 99) < 70);
      #1;
      sp = !hv || out_ready;
      ra = 1'b0; rb = 1'b0;
      if (sp) begin
        if (owner == 1) ra = 1'b1;
        else if (owner == 2) rb = 1'b1;
        else if (a_valid && b_valid) begin ra = !turn_b; rb = turn_b; end
        else begin ra = a_valid; rb = b_valid; end
      end
      tests++;
      if ({a_ready, b_ready} !== {ra, rb}) begin
        fails++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, {a_ready, b_ready}, {ra, rb});
      end
      xa = a_valid && ra;
      xb = b_valid && rb;
      if (xa) begin
        hv = 1'b1; hs = 1'b0; hl = a_last; hd = a_data; rem_a--; beats++;
        if (a_last) begin owner = 0; turn_b = 1'b1; end else owner = 1;
      end else if (xb) begin
        hv = 1'b1; hs = 1'b1; hl = b_last; hd = b_data; rem_b--; beats++;
        if (b_last) begin owner = 0; turn_b = 1'b0; end else owner = 2;
      end else if (out_ready) begin
        hv = 1'b0;
      end
      step();
      if (xa) a_valid = 1'b0;
      if (xb) b_valid = 1'b0;
      tests++;
      if ({out_valid, out_sel, out_last, out_data} !== {hv, hs, hl, hd}) begin
        fails++; $display("FAIL rand_out[%0d]: got %h want %h", cyc, {out_valid, out_sel, out_last, out_data}, {hv, hs, hl, hd});
      end
    end
    tests++;
    if (beats < 500) begin
      fails++; $display("FAIL rand_progress: got %0d beats want >= 500", beats);
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_contention();
    test_backpressure();
    test_stalled_lock();
    test_mid_packet_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
